// File: rtl/mem_req_issuer_if.sv
// mem_req_issuer_if: producer handshake, mem_system request/reply,
// completion record, statistics and error flags for mem_req_issuer.
interface mem_req_issuer_if;
  // producer side
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [15:0] req_exp;
  logic        req_chk;
  // mem_system request / reply
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  // completion record
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_hit;
  logic [4:0]  rsp_lat;
  // statistics
  logic [15:0] n_req;
  logic [15:0] n_hit;
  logic        err_perf;
  logic        err_data;
  logic        err_tmo;
  logic        clr_stats;

  // issuer view
  modport master (
    input  req_valid, req_wr, req_addr,
    input  req_data, req_exp, req_chk,
    output req_ready,
    output Rd, Wr, Addr, DataIn,
    input  DataOut, Done, Stall, CacheHit,
    output rsp_valid, rsp_data, rsp_hit, rsp_lat,
    output n_req, n_hit,
    output err_perf, err_data, err_tmo,
    input  clr_stats
  );

  // environment view (producer + mem_system)
  modport slave (
    output req_valid, req_wr, req_addr,
    output req_data, req_exp, req_chk,
    input  req_ready,
    input  Rd, Wr, Addr, DataIn,
    output DataOut, Done, Stall, CacheHit,
    input  rsp_valid, rsp_data, rsp_hit, rsp_lat,
    input  n_req, n_hit,
    input  err_perf, err_data, err_tmo,
    output clr_stats
  );
endinterface

// File: rtl/mem_req_issuer.sv
// mem_req_issuer: queues requests in a 4-deep FIFO, issues them to
// mem_system one at a time, checks latency/data, counts completions.
// Ports: clk, rst (async, active-high), bus (mem_req_issuer_if.master).
module mem_req_issuer #(
  parameter int HIT_MAX  = 2,
  parameter int MISS_MIN = 3,
  parameter int MISS_MAX = 20,
  parameter int TMO      = 31
) (
  input  logic clk,
  input  logic rst,
  mem_req_issuer_if.master bus
);

  localparam logic [4:0] L_HMAX = 5'(HIT_MAX);
  localparam logic [4:0] L_MMIN = 5'(MISS_MIN);
  localparam logic [4:0] L_MMAX = 5'(MISS_MAX);
  localparam logic [4:0] L_TMO  = 5'(TMO);

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
    logic        chk;
  } entry_t;

  typedef enum logic {IDLE, BUSY} state_t;

  entry_t      r_fifo [4];
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_cnt;

  state_t      r_state;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_din;
  logic [15:0] r_exp;
  logic        r_chk;
  logic [4:0]  r_lat;

  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_hit;
  logic [4:0]  r_rsp_lat;
  logic [15:0] r_n_req;
  logic [15:0] r_n_hit;
  logic        r_err_perf;
  logic        r_err_data;
  logic        r_err_tmo;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_done;
  logic        w_perf;
  entry_t      w_head;

  assign w_full  = (r_cnt == 3'd4);
  assign w_empty = (r_cnt == 3'd0);
  assign w_push  = bus.req_valid && !w_full;
  assign w_done  = (r_state == BUSY) && bus.Done;
  assign w_head  = r_fifo[r_rd_ptr];
  // Done issues back-to-back regardless of Stall
  assign w_pop   = !w_empty &&
                   (((r_state == IDLE) && !bus.Stall) || w_done);

  assign w_perf = bus.CacheHit ? (r_lat > L_HMAX)
                : ((r_lat < L_MMIN) || (r_lat > L_MMAX));

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= entry_t'{
      wr:   bus.req_wr,
      addr: bus.req_addr,
      data: bus.req_data,
      exp:  bus.req_exp,
      chk:  bus.req_chk
    };
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_exp       <= '0;
      r_chk       <= 1'b0;
      r_lat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_lat   <= '0;
      r_n_req     <= '0;
      r_n_hit     <= '0;
      r_err_perf  <= 1'b0;
      r_err_data  <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: ;
        BUSY: begin
          if (bus.Done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_wr ? 16'h0 : bus.DataOut;
            r_rsp_hit   <= bus.CacheHit;
            r_rsp_lat   <= r_lat;
            if (r_n_req != 16'hFFFF)
              r_n_req <= r_n_req + 16'd1;
            if (bus.CacheHit && (r_n_hit != 16'hFFFF))
              r_n_hit <= r_n_hit + 16'd1;
            if (w_perf) r_err_perf <= 1'b1;
            if (!r_wr && r_chk && (bus.DataOut != r_exp))
              r_err_data <= 1'b1;
            r_state <= IDLE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_lat   <= '0;
          end else if (r_lat == L_TMO) begin
            r_err_tmo <= 1'b1;
            r_state   <= IDLE;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_lat     <= '0;
          end else begin
            r_lat <= r_lat + 5'd1;
          end
        end
        default: ;
      endcase
      // a pop overrides the return to IDLE above
      if (w_pop) begin
        r_state <= BUSY;
        r_rd    <= !w_head.wr;
        r_wr    <= w_head.wr;
        r_addr  <= w_head.addr;
        r_din   <= w_head.data;
        r_exp   <= w_head.exp;
        r_chk   <= w_head.chk;
        r_lat   <= 5'd1;
      end
      // clear beats any coincident count/flag update
      if (bus.clr_stats) begin
        r_n_req    <= '0;
        r_n_hit    <= '0;
        r_err_perf <= 1'b0;
        r_err_data <= 1'b0;
        r_err_tmo  <= 1'b0;
      end
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.Rd        = r_rd;
  assign bus.Wr        = r_wr;
  assign bus.Addr      = r_addr;
  assign bus.DataIn    = r_din;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_lat   = r_rsp_lat;
  assign bus.n_req     = r_n_req;
  assign bus.n_hit     = r_n_hit;
  assign bus.err_perf  = r_err_perf;
  assign bus.err_data  = r_err_data;
  assign bus.err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_mem_req_issuer.sv
// tb_mem_req_issuer: directed checks of mem_req_issuer, with this
// bench acting as producer and as a scripted mem_system.
module tb_mem_req_issuer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_req_issuer_if bus ();

  mem_req_issuer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] e,
                      input logic c);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_exp   = e;
    bus.req_chk   = c;
    step();
    bus.req_valid = 1'b0;
  endtask

  // pre = cycles to wait before the Done cycle
  task automatic serve(input int pre, input logic hit,
                       input logic [15:0] d);
    repeat (pre) step();
    bus.Done     = 1'b1;
    bus.CacheHit = hit;
    bus.DataOut  = d;
    step();
    bus.Done     = 1'b0;
    bus.CacheHit = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_exp   = '0;
    bus.req_chk   = 1'b0;
    bus.DataOut   = '0;
    bus.Done      = 1'b0;
    bus.Stall     = 1'b0;
    bus.CacheHit  = 1'b0;
    bus.clr_stats = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rd", 32'(bus.Rd), 32'd0);
    chk("rst_wr", 32'(bus.Wr), 32'd0);
    chk("rst_addr", 32'(bus.Addr), 32'd0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_nreq", 32'(bus.n_req), 32'd0);
    chk("rst_tmo", 32'(bus.err_tmo), 32'd0);
    step();
    step();
    rst = 1'b0;

    // write, miss at lat 5
    push(1'b1, 16'h0010, 16'h1234, 16'h0, 1'b0);
    step();
    chk("w_wr", 32'(bus.Wr), 32'd1);
    chk("w_rd", 32'(bus.Rd), 32'd0);
    chk("w_addr", 32'(bus.Addr), 32'h10);
    chk("w_din", 32'(bus.DataIn), 32'h1234);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("w_hold", 32'(bus.Wr), 32'd1);
    end
    serve(0, 1'b0, 16'hDEAD);
    chk("w_rspv", 32'(bus.rsp_valid), 32'd1);
    chk("w_lat", 32'(bus.rsp_lat), 32'd5);
    chk("w_hit", 32'(bus.rsp_hit), 32'd0);
    chk("w_data", 32'(bus.rsp_data), 32'd0);
    chk("w_nreq", 32'(bus.n_req), 32'd1);
    chk("w_perf", 32'(bus.err_perf), 32'd0);
    chk("w_derr", 32'(bus.err_data), 32'd0);
    chk("w_wr_off", 32'(bus.Wr), 32'd0);
    step();
    chk("w_rspv_1cyc", 32'(bus.rsp_valid), 32'd0);

    // checked read, hit at lat 1
    push(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b1);
    step();
    chk("r_rd", 32'(bus.Rd), 32'd1);
    serve(0, 1'b1, 16'h1234);
    chk("r_data", 32'(bus.rsp_data), 32'h1234);
    chk("r_hit", 32'(bus.rsp_hit), 32'd1);
    chk("r_lat", 32'(bus.rsp_lat), 32'd1);
    chk("r_nhit", 32'(bus.n_hit), 32'd1);
    chk("r_nreq", 32'(bus.n_req), 32'd2);
    chk("r_derr", 32'(bus.err_data), 32'd0);
    chk("r_rd_off", 32'(bus.Rd), 32'd0);

    // bad data at lat 2 hit, then slow hit at lat 3
    push(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b1);
    step();
    serve(1, 1'b1, 16'hBEEF);
    chk("bd_derr", 32'(bus.err_data), 32'd1);
    chk("bd_perf", 32'(bus.err_perf), 32'd0);
    chk("bd_data", 32'(bus.rsp_data), 32'hBEEF);
    chk("bd_lat", 32'(bus.rsp_lat), 32'd2);
    push(1'b0, 16'h0012, 16'h0, 16'h0, 1'b0);
    step();
    serve(2, 1'b1, 16'h0);
    chk("sh_perf", 32'(bus.err_perf), 32'd1);
    chk("sh_derr_sticky", 32'(bus.err_data), 32'd1);
    chk("sh_lat", 32'(bus.rsp_lat), 32'd3);
    chk("sh_nreq", 32'(bus.n_req), 32'd4);
    chk("sh_nhit", 32'(bus.n_hit), 32'd3);

    // fill FIFO while stalled
    bus.Stall     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_chk   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr = 16'h0100 + 16'(i);
      step();
    end
    chk("f_full", 32'(bus.req_ready), 32'd0);
    bus.req_addr = 16'h0104;
    step();
    chk("f_full2", 32'(bus.req_ready), 32'd0);
    chk("f_stall_rd", 32'(bus.Rd), 32'd0);
    bus.Stall = 1'b0;
    step();
    chk("f_pop_rd", 32'(bus.Rd), 32'd1);
    chk("f_pop_addr", 32'(bus.Addr), 32'h100);
    chk("f_pop_ready", 32'(bus.req_ready), 32'd1);
    bus.Stall = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("f_5th_in", 32'(bus.req_ready), 32'd0);
    serve(0, 1'b1, 16'h0A00);
    chk("f_d0", 32'(bus.rsp_data), 32'h0A00);
    chk("f_lat0", 32'(bus.rsp_lat), 32'd2);
    chk("f_b2b_rd", 32'(bus.Rd), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("f_order", 32'(bus.Addr), 32'h100 + 32'(i));
      serve(0, 1'b1, 16'h0A00 + 16'(i));
      chk("f_data", 32'(bus.rsp_data), 32'h0A00 + 32'(i));
    end
    chk("f_idle_rd", 32'(bus.Rd), 32'd0);
    chk("f_nreq", 32'(bus.n_req), 32'd9);
    chk("f_nhit", 32'(bus.n_hit), 32'd8);
    bus.Stall = 1'b0;

    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    chk("c_nreq", 32'(bus.n_req), 32'd0);
    chk("c_perf", 32'(bus.err_perf), 32'd0);
    chk("c_derr", 32'(bus.err_data), 32'd0);

    // timeout, then next queued request issues
    push(1'b0, 16'h0200, 16'h0, 16'h0, 1'b0);
    push(1'b0, 16'h0201, 16'h0, 16'h0, 1'b0);
    chk("t_rd", 32'(bus.Rd), 32'd1);
    chk("t_addr", 32'(bus.Addr), 32'h200);
    repeat (30) step();
    chk("t_rd31", 32'(bus.Rd), 32'd1);
    chk("t_tmo31", 32'(bus.err_tmo), 32'd0);
    step();
    chk("t_tmo", 32'(bus.err_tmo), 32'd1);
    chk("t_rd_off", 32'(bus.Rd), 32'd0);
    chk("t_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("t_nreq", 32'(bus.n_req), 32'd0);
    step();
    chk("t_next_rd", 32'(bus.Rd), 32'd1);
    chk("t_next_addr", 32'(bus.Addr), 32'h201);
    bus.clr_stats = 1'b1;
    serve(0, 1'b1, 16'h5555);
    bus.clr_stats = 1'b0;
    chk("cd_rspv", 32'(bus.rsp_valid), 32'd1);
    chk("cd_nreq", 32'(bus.n_req), 32'd0);
    chk("cd_nhit", 32'(bus.n_hit), 32'd0);
    chk("cd_tmo", 32'(bus.err_tmo), 32'd0);

    // Done while IDLE
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    chk("i_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("i_nreq", 32'(bus.n_req), 32'd0);

    // reset mid-request
    push(1'b0, 16'h02FF, 16'h0, 16'h0, 1'b0);
    step();
    serve(0, 1'b1, 16'h0);
    chk("m_nreq", 32'(bus.n_req), 32'd1);
    push(1'b1, 16'h0300, 16'hAAAA, 16'h0, 1'b0);
    push(1'b1, 16'h0301, 16'hBBBB, 16'h0, 1'b0);
    repeat (3) step();
    chk("m_wr_lat4", 32'(bus.Wr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("m_wr", 32'(bus.Wr), 32'd0);
    chk("m_rd", 32'(bus.Rd), 32'd0);
    chk("m_nreq0", 32'(bus.n_req), 32'd0);
    chk("m_ready", 32'(bus.req_ready), 32'd1);
    chk("m_addr", 32'(bus.Addr), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("m_post_wr", 32'(bus.Wr), 32'd0);
    chk("m_post_rspv", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_issuer.md
MEM_REQ_ISSUER -- requirements
Module: mem_req_issuer

Interface
REQ-001 SHALL have parameter HIT_MAX, default 2, max legal latency of a CacheHit completion.
REQ-002 SHALL have parameter MISS_MIN, default 3, min legal latency of a miss completion.
REQ-003 SHALL have parameter MISS_MAX, default 20, max legal latency of a miss completion.
REQ-004 SHALL have parameter TMO, default 31, latency at which an outstanding request is abandoned.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1  producer handshake; transfer when both high at an edge.
REQ-008 SHALL have ports req_wr in 1, req_addr in 16, req_data in 16, req_exp in 16, req_chk in 1  op (1=write), address, write data, expected read data, compare enable.
REQ-009 SHALL have ports Rd out 1, Wr out 1, Addr out 16, DataIn out 16  request to mem_system.
REQ-010 SHALL have ports DataOut in 16, Done in 1, Stall in 1, CacheHit in 1  reply from mem_system.
REQ-011 SHALL have ports rsp_valid out 1, rsp_data out 16, rsp_hit out 1, rsp_lat out 5  one-cycle completion record.
REQ-012 SHALL have ports n_req out 16, n_hit out 16  completed-request and hit counters.
REQ-013 SHALL have ports err_perf, err_data, err_tmo out 1 each  sticky error flags.
REQ-014 SHALL have port clr_stats in 1  synchronous clear of counters and error flags.

Function
REQ-015 SHALL buffer accepted requests in a 4-entry FIFO, in order; req_ready = !full.
REQ-016 SHALL accept a push on the same edge as a pop when not full; when full, req_ready low, no push.
REQ-017 SHALL implement FSM states IDLE, BUSY.
REQ-018 IDLE -> BUSY when FIFO non-empty and Stall=0: pop head, drive Rd=!wr, Wr=wr, Addr, DataIn from registered head fields.
REQ-019 In BUSY, SHALL hold Rd/Wr/Addr/DataIn stable until the edge after Done=1 or timeout.
REQ-020 SHALL keep lat counter: 1 in first BUSY cycle, +1 per cycle, saturating at TMO.
REQ-021 On a BUSY cycle with Done=1: next edge rsp_valid=1, rsp_data=DataOut (0 for writes), rsp_hit=CacheHit, rsp_lat=lat.
REQ-022 On Done, if FIFO non-empty SHALL issue next request back-to-back (BUSY, lat=1) ignoring Stall; else IDLE with Rd=Wr=0.
REQ-023 SHALL set err_perf if CacheHit=1 and lat>HIT_MAX, or CacheHit=0 and (lat<MISS_MIN or lat>MISS_MAX).
REQ-024 SHALL set err_data if read, req_chk=1 and DataOut != req_exp at Done.
REQ-025 If lat reaches TMO with Done=0: set err_tmo, drop request, no rsp_valid, no count, deassert Rd/Wr, go IDLE.
REQ-026 On Done SHALL increment n_req, and n_hit if CacheHit; both saturate at 16'hFFFF.
REQ-027 clr_stats=1 SHALL zero n_req, n_hit, all err flags next edge; clear wins over a coincident Done update (event not counted, flags not set).
REQ-028 Done while IDLE SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately: FIFO empty, state IDLE, Rd=Wr=0, Addr=DataIn=0, rsp_*=0, counters=0, err flags=0, lat=0.
REQ-030 rst mid-request SHALL abandon it without response; req_ready=1 during reset.

Verification
REQ-031 Write 0x0010 data 0x1234, model misses Done at lat 5 -> Wr held 5 cycles, rsp_lat=5, rsp_hit=0, n_req=1, no errors.
REQ-032 Read 0x0010 exp 0x1234 chk=1, Done+CacheHit at lat 1 -> rsp_data=0x1234, rsp_hit=1, n_hit=1, err_data=0.
REQ-033 Read returns 0xBEEF vs exp 0x1234 at lat 2 hit -> err_data=1 sticky; CacheHit at lat 3 -> err_perf=1.
REQ-034 Push 5 requests back-to-back with model stalled -> req_ready low after 4th; 5th accepted after first pop; order preserved.
REQ-035 Never assert Done -> at lat 31 err_tmo=1, Rd=0, next queued request issues; clr_stats same cycle as a Done -> n_req=0.
REQ-036 Assert rst while BUSY at lat 4 -> Rd/Wr=0, n_req=0, req_ready=1 immediately.
